// File: rtl/traffic_lights_decoder_if.sv
// Lamp-line and recovered-phase bundle for traffic_lights_decoder.
// master drives the lamp lines; slave is the decoder.
interface traffic_lights_decoder_if;
   logic [0:2]  ld;
   logic [0:1]  state;
   logic        state_valid;
   logic        state_change;
   logic        seq_error;
   logic [15:0] dwell_count;

   modport master (
      output ld,
      input  state, state_valid, state_change, seq_error, dwell_count
   );

   modport slave (
      input  ld,
      output state, state_valid, state_change, seq_error, dwell_count
   );
endinterface

// File: rtl/traffic_lights_decoder.sv
// Recovers the traffic-light phase from asynchronous lamp lines: sync, debounce, sequence FSM.
// Optional dwell counter is built only when TRAFFIC_LIGHTS_DECODER_DWELL_EN is defined.
module traffic_lights_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input logic                     clk,
   input logic                     rst,
   traffic_lights_decoder_if.slave bus
);

   typedef enum logic [2:0] {
      S_UNSYNC,
      S_GREEN,
      S_YELLOW1,
      S_RED,
      S_YELLOW2
   } fsm_t;

   typedef enum logic [1:0] {
      P_G,
      P_Y,
      P_R,
      P_X
   } pat_t;

   localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES);

   logic [0:2] sync1;
   logic [0:2] sync2;
   logic [0:2] db_last;
   logic [7:0] db_cnt;
   logic       acc_stb;
   pat_t       pat;
   fsm_t       fsm;
   fsm_t       fsm_nxt;
   logic       err_nxt;
   logic [0:1] state_q;
   logic       valid_q;
   logic       change_q;
   logic       err_q;

   // NOTE: every flop uses non-blocking assignment so all of them sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
      end else begin
         sync1 <= bus.ld;
         sync2 <= sync1;
      end
   end

   // Any change restarts the count; acc_stb fires once when the count first reaches DB_MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_last <= 3'b000;
         db_cnt  <= 8'd0;
         acc_stb <= 1'b0;
      end else if (sync2 != db_last) begin
         db_last <= sync2;
         db_cnt  <= 8'd1;
         acc_stb <= (DB_MAX == 8'd1);
      end else if (db_cnt < DB_MAX) begin
         db_cnt  <= db_cnt + 8'd1;
         acc_stb <= ((db_cnt + 8'd1) == DB_MAX);
      end else begin
         acc_stb <= 1'b0;
      end
   end

   // NOTE: each always_comb assigns its outputs a default first so no path infers a latch.
   always_comb begin
      pat = P_X;
      case (db_last)
         3'b100:  pat = P_G;
         3'b010:  pat = P_Y;
         3'b001:  pat = P_R;
         default: pat = P_X;
      endcase
   end

   function automatic fsm_t resync(input pat_t p);
      case (p)
         P_G:     return S_GREEN;
         P_R:     return S_RED;
         default: return S_UNSYNC;
      endcase
   endfunction

   function automatic logic [0:1] encode(input fsm_t s);
      case (s)
         S_YELLOW1: return 2'b01;
         S_YELLOW2: return 2'b10;
         S_RED:     return 2'b11;
         default:   return 2'b00;
      endcase
   endfunction

   always_comb begin
      fsm_nxt = fsm;
      err_nxt = 1'b0;
      if (acc_stb) begin
         case (fsm)
            S_UNSYNC: begin
               // Yellow alone cannot tell YELLOW1 from YELLOW2, so only G or R syncs.
               if (pat == P_G || pat == P_R) fsm_nxt = resync(pat);
            end
            S_GREEN: begin
               if (pat == P_Y) fsm_nxt = S_YELLOW1;
               else if (pat != P_G) begin
                  err_nxt = 1'b1;
                  fsm_nxt = resync(pat);
               end
            end
            S_YELLOW1: begin
               if (pat == P_R) fsm_nxt = S_RED;
               else if (pat != P_Y) begin
                  err_nxt = 1'b1;
                  fsm_nxt = resync(pat);
               end
            end
            S_RED: begin
               if (pat == P_Y) fsm_nxt = S_YELLOW2;
               else if (pat != P_R) begin
                  err_nxt = 1'b1;
                  fsm_nxt = resync(pat);
               end
            end
            S_YELLOW2: begin
               if (pat == P_G) fsm_nxt = S_GREEN;
               else if (pat != P_Y) begin
                  err_nxt = 1'b1;
                  fsm_nxt = resync(pat);
               end
            end
            default: fsm_nxt = S_UNSYNC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm      <= S_UNSYNC;
         state_q  <= 2'b00;
         valid_q  <= 1'b0;
         change_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         fsm      <= fsm_nxt;
         state_q  <= encode(fsm_nxt);
         valid_q  <= (fsm_nxt != S_UNSYNC);
         change_q <= (fsm_nxt != fsm);
         err_q    <= err_nxt;
      end
   end

   assign bus.state        = state_q;
   assign bus.state_valid  = valid_q;
   assign bus.state_change = change_q;
   assign bus.seq_error    = err_q;

`ifdef TRAFFIC_LIGHTS_DECODER_DWELL_EN
   logic [15:0] dwell_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_q <= 16'h0000;
      end else if (fsm_nxt != fsm) begin
         dwell_q <= 16'h0000;
      end else if (dwell_q != 16'hFFFF) begin
         dwell_q <= dwell_q + 16'h0001;
      end
   end

   assign bus.dwell_count = dwell_q;
`else
   assign bus.dwell_count = 16'h0000;
`endif

endmodule

// File: doc/traffic_lights_decoder.md
TRAFFIC_LIGHTS_DECODER -- requirements
Module: traffic_lights_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles required to accept a lamp pattern (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ld, input, [0:2]: lamp lines, asynchronous to clk; ld[0] is green, ld[1] is yellow, ld[2] is red.
REQ-005 SHALL have port state, output, [0:1]: recovered phase, encoded green=00, yellow1=01, yellow2=10, red=11.
REQ-006 SHALL have port state_valid, output, 1 bit: state is trustworthy.
REQ-007 SHALL have port state_change, output, 1 bit: one-cycle pulse when state or state_valid changes.
REQ-008 SHALL have port seq_error, output, 1 bit: one-cycle pulse on an illegal pattern or transition.
REQ-009 SHALL have port dwell_count, output, [15:0]: cycles spent in the current state.

Function
REQ-010 SHALL pass ld through a 2-flop synchronizer before any other logic.
REQ-011 SHALL accept a synchronized pattern only after it is unchanged for DEBOUNCE_CYCLES consecutive cycles; shorter glitches SHALL be ignored.
REQ-012 SHALL update outputs DEBOUNCE_CYCLES+3 cycles after the first edge sampling a new stable ld value (2 sync, DEBOUNCE_CYCLES debounce, 1 register).
REQ-013 SHALL classify accepted patterns (ld[0],ld[1],ld[2]) as: 100 = G, 010 = Y, 001 = R; all other patterns (000, 110, 111, ...) are illegal (X).
REQ-014 SHALL implement the FSM states UNSYNC, GREEN, YELLOW1, RED and YELLOW2.
REQ-015 The legal cycle SHALL be GREEN -Y-> YELLOW1 -R-> RED -Y-> YELLOW2 -G-> GREEN; re-acceptance of the same pattern SHALL leave the state unchanged.
REQ-016 From UNSYNC, G SHALL go to GREEN and R SHALL go to RED; Y and X SHALL stay in UNSYNC with no seq_error, because yellow alone is ambiguous.
REQ-017 An illegal transition from a synced state (for example GREEN on R, or YELLOW1 on G) SHALL pulse seq_error and resync immediately: G goes to GREEN, R goes to RED, Y goes to UNSYNC.
REQ-018 X accepted in any synced state SHALL pulse seq_error and go to UNSYNC.
REQ-019 In UNSYNC, state_valid SHALL be 0 and state SHALL be 00; in all other FSM states, state_valid SHALL be 1 and state SHALL carry the REQ-005 encoding.
REQ-020 state_change SHALL pulse on the same edge where state or state_valid changes; seq_error and state_change MAY assert together.
REQ-021 dwell_count SHALL clear to 0 on every FSM state change, otherwise increment by 1 per cycle, and saturate at 16'hFFFF (no wrap).
REQ-022 A new ld change during an ongoing debounce SHALL restart the debounce count from zero.

Reset
REQ-023 While rst=1, asynchronously: the FSM SHALL be UNSYNC; state=00; state_valid, state_change and seq_error SHALL be 0; dwell_count=0; synchronizer and debounce registers SHALL be 0.
REQ-024 After rst deasserts, the pattern present SHALL undergo full sync and debounce before acceptance; no output pulse SHALL occur on reset release.
REQ-025 rst asserted mid-debounce or mid-state SHALL discard all progress with no residual pulse.

Configuration
REQ-026 With macro TRAFFIC_LIGHTS_DECODER_DWELL_EN defined, the REQ-021 dwell counter SHALL be built.
REQ-027 Without TRAFFIC_LIGHTS_DECODER_DWELL_EN, dwell_count SHALL be constant 16'h0000 and no counter flops SHALL exist; all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=4, macro defined unless noted)
REQ-028 Reset, then hold ld=100 -> state_valid=1, state=00 and state_change pulses exactly 7 cycles after the first sampling edge; no seq_error.
REQ-029 Full cycle 100 -> 010 -> 001 -> 010 -> 100, each held 20 cycles -> state sequence 00, 01, 11, 10, 00 with 5 state_change pulses (including the initial sync) and zero seq_error.
REQ-030 In GREEN, a 3-cycle ld=001 glitch -> no state change and no pulses; dwell_count keeps incrementing.
REQ-031 In GREEN, hold ld=001 -> seq_error and state_change pulse together and state=11 with state_valid=1; then hold ld=110 -> seq_error pulses and state_valid=0.
REQ-032 After reset, hold ld=010 for 50 cycles -> state_valid stays 0 with no pulses; then ld=001 -> RED.
REQ-033 Hold GREEN for 70000 cycles -> dwell_count saturates at 16'hFFFF; rebuilding without the macro gives dwell_count=0 throughout.
